cdb_broadcaster: RTL

- Transmit end of the common data bus: collects completed results from the functional units and drives up to WAYS CDB lanes per cycle.
- Outputs CDB_Data, CDB_PRF_idx and CDB_valid, consumed by every RS_Line, the ROB and the PRF.
- Results that exceed lane capacity are held in an age-ordered circular queue.
- Upstream units see backpressure through fu_ready.

---
 rtl/cdb_broadcaster.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/cdb_broadcaster.sv
// Common data bus transmit stage: merges queued and freshly completed FU results
// into up to WAYS registered broadcast lanes, overflowing into an age-ordered FIFO.
module cdb_broadcaster #(
   parameter int WAYS   = 3,
   parameter int N_FU   = 4,
   parameter int QDEPTH = 8,
   parameter int XLEN   = 32,
   parameter int PRF    = 64,
   parameter int ROB    = 16
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           squash,
   input  logic [N_FU-1:0]                fu_valid,
   input  logic [N_FU*XLEN-1:0]           fu_data,
   input  logic [N_FU*$clog2(PRF)-1:0]    fu_PRF_idx,
   input  logic [N_FU*$clog2(ROB)-1:0]    fu_rob_idx,
   output logic                           fu_ready,
   output logic [WAYS*XLEN-1:0]           CDB_Data,
   output logic [WAYS*$clog2(PRF)-1:0]    CDB_PRF_idx,
   output logic [WAYS*$clog2(ROB)-1:0]    CDB_rob_idx,
   output logic [WAYS-1:0]                CDB_valid,
   output logic [$clog2(QDEPTH):0]        q_count
);

   localparam int PW = $clog2(PRF);
   localparam int RW = $clog2(ROB);
   localparam int AW = $clog2(QDEPTH);
   localparam int CW = AW + 1;
   localparam int EW = XLEN + PW + RW;

   logic [EW-1:0]        r_mem [QDEPTH];
   logic [AW-1:0]        r_head;
   logic [AW-1:0]        r_tail;
   logic [CW-1:0]        r_count;
   logic [WAYS*XLEN-1:0] r_cdb_data;
   logic [WAYS*PW-1:0]   r_cdb_prf;
   logic [WAYS*RW-1:0]   r_cdb_rob;
   logic [WAYS-1:0]      r_cdb_valid;

   logic                 w_ready;
   logic [N_FU-1:0]      w_acc;
   logic [EW-1:0]        w_port [N_FU];
   logic [EW-1:0]        w_lane [WAYS];
   logic [WAYS-1:0]      w_lane_v;
   logic [N_FU-1:0]      w_wr_en;
   logic [AW-1:0]        w_wr_addr [N_FU];
   logic [AW-1:0]        w_head_nxt;
   logic [AW-1:0]        w_tail_nxt;
   logic [CW-1:0]        w_count_nxt;

   assign w_ready     = (r_count <= CW'(QDEPTH - N_FU));
   assign fu_ready    = w_ready;
   assign q_count     = r_count;
   assign CDB_Data    = r_cdb_data;
   assign CDB_PRF_idx = r_cdb_prf;
   assign CDB_rob_idx = r_cdb_rob;
   assign CDB_valid   = r_cdb_valid;

   // Queue entries fill lanes first; accepted ports take the remaining lanes by
   // rank, and any port whose rank exceeds the free lanes spills to tail+offset.
   always_comb begin
      int unsigned n_q;
      int unsigned n_acc;
      int unsigned n_deq;
      int unsigned skip;
      int unsigned n_bc;
      int unsigned n_left;
      int unsigned rank [N_FU];

      w_acc     = '0;
      w_lane_v  = '0;
      w_wr_en   = '0;
      n_acc     = 0;
      n_q       = 32'(r_count);
      n_deq     = (n_q < WAYS) ? n_q : WAYS;
      skip      = WAYS - n_deq;

      for (int unsigned i = 0; i < N_FU; i++) begin
         w_port[i]    = {fu_rob_idx[i*RW +: RW], fu_PRF_idx[i*PW +: PW], fu_data[i*XLEN +: XLEN]};
         w_wr_addr[i] = '0;
         w_acc[i]     = fu_valid[i] && w_ready;
         rank[i]      = n_acc;
         if (w_acc[i]) n_acc = n_acc + 1;
      end

      for (int unsigned l = 0; l < WAYS; l++) begin
         w_lane[l] = '0;
         if (l < n_deq) begin
            w_lane[l]   = r_mem[r_head + AW'(l)];
            w_lane_v[l] = 1'b1;
         end else begin
            for (int unsigned i = 0; i < N_FU; i++) begin
               if (w_acc[i] && rank[i] == l - n_deq) begin
                  w_lane[l]   = w_port[i];
                  w_lane_v[l] = 1'b1;
               end
            end
         end
      end

      for (int unsigned i = 0; i < N_FU; i++) begin
         if (w_acc[i] && rank[i] >= skip) begin
            w_wr_en[i]   = 1'b1;
            w_wr_addr[i] = r_tail + AW'(rank[i] - skip);
         end
      end

      n_bc        = ((n_q + n_acc) < WAYS) ? (n_q + n_acc) : WAYS;
      n_left      = (n_acc > skip) ? (n_acc - skip) : 0;
      w_head_nxt  = r_head + AW'(n_deq);
      w_tail_nxt  = r_tail + AW'(n_left);
      w_count_nxt = CW'(n_q + n_acc - n_bc);
   end

   always_ff @(posedge clock) begin
      if (reset || squash) begin
         r_head      <= '0;
         r_tail      <= '0;
         r_count     <= '0;
         r_cdb_data  <= '0;
         r_cdb_prf   <= '0;
         r_cdb_rob   <= '0;
         r_cdb_valid <= '0;
      end else begin
         r_head      <= w_head_nxt;
         r_tail      <= w_tail_nxt;
         r_count     <= w_count_nxt;
         r_cdb_valid <= w_lane_v;
         for (int unsigned l = 0; l < WAYS; l++) begin
            r_cdb_data[l*XLEN +: XLEN] <= w_lane[l][XLEN-1:0];
            r_cdb_prf[l*PW +: PW]      <= w_lane[l][XLEN +: PW];
            r_cdb_rob[l*RW +: RW]      <= w_lane[l][XLEN+PW +: RW];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && !squash) begin
         for (int unsigned i = 0; i < N_FU; i++) begin
            if (w_wr_en[i]) r_mem[w_wr_addr[i]] <= w_port[i];
         end
      end
   end

endmodule
